// File: rtl/rename_ckpt_if.sv
// Rename group bundle: one group of lanes in, registered rename results out,
// plus checkpoint recovery controls.
interface rename_ckpt_if #(
   parameter int WIDTH = 4,
   parameter int PRW   = 7,
   parameter int ARW   = 5,
   parameter int NCKPT = 4
);
   localparam int CKW = $clog2(NCKPT);

   logic                   i_en;
   logic [WIDTH*3*ARW-1:0] i_rg;
   logic [WIDTH-1:0]       i_wen;
   logic [WIDTH*PRW-1:0]   i_freelist;
   logic [WIDTH-1:0]       i_flvalid;
   logic [WIDTH-1:0]       i_ckpt;
   logic                   i_restore;
   logic [CKW-1:0]         i_restore_id;
   logic                   i_release;
   logic [WIDTH*PRW-1:0]   o_prs1;
   logic [WIDTH*PRW-1:0]   o_prs2;
   logic [WIDTH*PRW-1:0]   o_prd;
   logic [WIDTH*PRW-1:0]   o_oldprd;
   logic                   o_valid;
   logic [WIDTH-1:0]       o_enfreelist;
   logic                   o_stall;
   logic [CKW-1:0]         o_ckpt_id;
   logic                   o_ckpt_full;

   modport master (
      output i_en, i_rg, i_wen, i_freelist, i_flvalid, i_ckpt,
      output i_restore, i_restore_id, i_release,
      input  o_prs1, o_prs2, o_prd, o_oldprd, o_valid,
      input  o_enfreelist, o_stall, o_ckpt_id, o_ckpt_full
   );

   modport slave (
      input  i_en, i_rg, i_wen, i_freelist, i_flvalid, i_ckpt,
      input  i_restore, i_restore_id, i_release,
      output o_prs1, o_prs2, o_prd, o_oldprd, o_valid,
      output o_enfreelist, o_stall, o_ckpt_id, o_ckpt_full
   );
endinterface

// File: rtl/rename_ckpt.sv
// Register rename stage: map table with intra-group bypass and a circular
// buffer of branch checkpoints for mispredict recovery.
module rename_ckpt #(
   parameter int WIDTH = 4,
   parameter int PRW   = 7,
   parameter int ARW   = 5,
   parameter int NCKPT = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   rename_ckpt_if.slave  bus
);
   localparam int CKW = $clog2(NCKPT);
   localparam int NAR = 1 << ARW;
   localparam int CNW = $clog2(WIDTH + 1);
   localparam logic [CKW:0] CMAX = (CKW+1)'(NCKPT);

   typedef logic [PRW-1:0] tag_t;

   tag_t map_q [NAR];
   tag_t snap_q [NCKPT][NAR];
   tag_t cur [NAR];
   tag_t snap_d [NAR];
   tag_t tag;

   logic [ARW-1:0] rs1, rs2, rd;
   logic [WIDTH*PRW-1:0] prs1_d, prs2_d, prd_d, old_d;
   logic [CNW-1:0] ncons;
   logic [WIDTH-1:0] efl;
   logic [CKW-1:0] head_q, tail_q, head_n;
   logic [CKW:0] cnt_q;
   logic ckpt_any, full, stall, accept, rel_ok, take;

   // Walk the lanes in order on a working copy so later lanes see earlier writes.
   always_comb begin
      cur = map_q;
      snap_d = map_q;
      prs1_d = '0;
      prs2_d = '0;
      prd_d = '0;
      old_d = '0;
      ncons = '0;
      rs1 = '0;
      rs2 = '0;
      rd = '0;
      tag = '0;
      for (int l = 0; l < WIDTH; l++) begin
         rs1 = bus.i_rg[l*3*ARW +: ARW];
         rs2 = bus.i_rg[l*3*ARW+ARW +: ARW];
         rd  = bus.i_rg[l*3*ARW+2*ARW +: ARW];
         if (rs1 != '0) prs1_d[l*PRW +: PRW] = cur[rs1];
         if (rs2 != '0) prs2_d[l*PRW +: PRW] = cur[rs2];
         if (bus.i_wen[l] && rd != '0) begin
            tag = bus.i_freelist[int'(ncons)*PRW +: PRW];
            prd_d[l*PRW +: PRW] = tag;
            old_d[l*PRW +: PRW] = cur[rd];
            cur[rd] = tag;
            ncons = ncons + CNW'(1);
         end
         if (bus.i_ckpt[l]) snap_d = cur;
      end
   end

   assign ckpt_any = |bus.i_ckpt;
   assign full = (cnt_q == CMAX);
   assign stall = bus.i_en && !bus.i_restore &&
                  ((int'(ncons) > $countones(bus.i_flvalid)) ||
                   (ckpt_any && full));
   assign accept = bus.i_en && !bus.i_restore && !stall;
   assign take = accept && ckpt_any;
   assign rel_ok = bus.i_release && (cnt_q != '0);
   assign head_n = head_q + CKW'(rel_ok);

   always_comb begin
      efl = '0;
      for (int l = 0; l < WIDTH; l++)
         efl[l] = accept && (l < int'(ncons));
   end

   assign bus.o_enfreelist = efl;
   assign bus.o_stall = stall;
   assign bus.o_ckpt_full = full;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NAR; i++) map_q[i] <= tag_t'(i);
         head_q <= '0;
         tail_q <= '0;
         cnt_q <= '0;
      end else if (bus.i_restore) begin
         map_q <= snap_q[bus.i_restore_id];
         head_q <= head_n;
         tail_q <= bus.i_restore_id;
         cnt_q <= {1'b0, CKW'(bus.i_restore_id - head_n)};
      end else begin
         if (accept) map_q <= cur;
         head_q <= head_n;
         tail_q <= tail_q + CKW'(take);
         cnt_q <= cnt_q + (CKW+1)'(take) - (CKW+1)'(rel_ok);
      end
   end

   // Snapshot storage carries no reset; its contents only matter once written.
   always_ff @(posedge i_clk) begin
      if (take) snap_q[tail_q] <= snap_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_prs1 <= '0;
         bus.o_prs2 <= '0;
         bus.o_prd <= '0;
         bus.o_oldprd <= '0;
         bus.o_valid <= 1'b0;
         bus.o_ckpt_id <= '0;
      end else begin
         bus.o_valid <= accept;
         if (accept) begin
            bus.o_prs1 <= prs1_d;
            bus.o_prs2 <= prs2_d;
            bus.o_prd <= prd_d;
            bus.o_oldprd <= old_d;
         end
         if (take) bus.o_ckpt_id <= tail_q;
      end
   end
endmodule

// File: tb/tb_rename_ckpt.sv
// Directed bench for rename_ckpt: bypass, stall, checkpoint fill/wrap,
// restore and mid-stream reset.
module tb_rename_ckpt;
   localparam int W = 4;
   localparam int PRW = 7;
   localparam int ARW = 5;
   localparam int NC = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rename_ckpt_if #(.WIDTH(W), .PRW(PRW), .ARW(ARW), .NCKPT(NC)) bus ();

   rename_ckpt #(.WIDTH(W), .PRW(PRW), .ARW(ARW), .NCKPT(NC)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus.slave)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] ln(input int rd, input int rs2, input int rs1);
      ln = {5'(rd), 5'(rs2), 5'(rs1)};
   endfunction

   // Lane 0 is the first argument.
   function automatic logic [27:0] t4(input int a, input int b,
                                      input int c, input int d);
      t4 = {7'(d), 7'(c), 7'(b), 7'(a)};
   endfunction

   task automatic idle();
      bus.i_en = 1'b0;
      bus.i_rg = '0;
      bus.i_wen = '0;
      bus.i_freelist = '0;
      bus.i_flvalid = '0;
      bus.i_ckpt = '0;
      bus.i_restore = 1'b0;
      bus.i_restore_id = '0;
      bus.i_release = 1'b0;
   endtask

   task automatic drive(input logic [59:0] rg, input logic [3:0] wen,
                        input logic [27:0] fl, input logic [3:0] flv,
                        input logic [3:0] ckpt);
      @(negedge clk);
      idle();
      bus.i_en = 1'b1;
      bus.i_rg = rg;
      bus.i_wen = wen;
      bus.i_freelist = fl;
      bus.i_flvalid = flv;
      bus.i_ckpt = ckpt;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read-only group: lane0 {rs2=b, rs1=a}, lane1 {rs2=d, rs1=c}.
   task automatic probe(input string tag, input int a, input int b,
                        input int c, input int d, input int ea, input int eb,
                        input int ec, input int ed);
      drive({15'd0, 15'd0, ln(0, d, c), ln(0, b, a)}, 4'b0000, '0, 4'b1111, 4'b0000);
      tick();
      chk({tag, "_prs1"}, bus.o_prs1, t4(ea, ec, 0, 0));
      chk({tag, "_prs2"}, bus.o_prs2, t4(eb, ed, 0, 0));
   endtask

   initial begin
      idle();
      #12;
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_prd", bus.o_prd, 0);
      chk("rst_full", bus.o_ckpt_full, 0);
      @(negedge clk);
      rst_n = 1'b1;

      drive({ln(4,0,0), ln(3,0,0), ln(2,0,0), ln(1,0,0)}, 4'b1111,
            t4('h11,'h12,'h13,'h14), 4'b1111, 4'b0000);
      chk("g1_stall", bus.o_stall, 0);
      chk("g1_efl", bus.o_enfreelist, 4'b1111);
      tick();
      chk("g1_valid", bus.o_valid, 1);
      chk("g1_prd", bus.o_prd, t4('h11,'h12,'h13,'h14));
      chk("g1_old", bus.o_oldprd, t4(1,2,3,4));
      chk("g1_prs1", bus.o_prs1, 0);

      drive({ln(3,0,3), ln(3,1,0), ln(1,0,1), ln(1,0,1)}, 4'b1111,
            t4('h15,'h16,'h17,'h18), 4'b1111, 4'b0000);
      tick();
      chk("g2_prs1", bus.o_prs1, t4('h11,'h15,0,'h17));
      chk("g2_prs2", bus.o_prs2, t4(0,0,'h16,0));
      chk("g2_old", bus.o_oldprd, t4('h11,'h15,'h13,'h17));
      chk("g2_prd", bus.o_prd, t4('h15,'h16,'h17,'h18));

      drive({ln(0,0,0), ln(7,0,0), ln(6,0,0), ln(5,0,0)}, 4'b0111,
            t4('h19,'h1a,'h1b,'h1c), 4'b0011, 4'b0000);
      chk("g3_stall", bus.o_stall, 1);
      chk("g3_efl", bus.o_enfreelist, 0);
      tick();
      chk("g3_valid", bus.o_valid, 0);
      chk("g3_hold", bus.o_prd, t4('h15,'h16,'h17,'h18));
      probe("map2", 1, 3, 5, 2, 'h16, 'h18, 5, 'h12);

      drive({ln(0,0,0), ln(1,0,0), ln(1,0,0), ln(2,0,0)}, 4'b0111,
            t4('h20,'h21,'h22,'h23), 4'b1111, 4'b0010);
      chk("ck_efl", bus.o_enfreelist, 4'b0111);
      tick();
      chk("ck_id", bus.o_ckpt_id, 0);
      chk("ck_prd", bus.o_prd, t4('h20,'h21,'h22,0));
      chk("ck_old", bus.o_oldprd, t4('h12,'h16,'h21,0));
      drive({45'd0, ln(1,0,0)}, 4'b0001, t4('h24,0,0,0), 4'b1111, 4'b0000);
      tick();
      chk("post_old", bus.o_oldprd, t4('h22,0,0,0));
      drive({45'd0, ln(4,0,0)}, 4'b0001, t4('h25,0,0,0), 4'b1111, 4'b0000);
      bus.i_restore = 1'b1;
      bus.i_restore_id = 2'd0;
      #1;
      chk("rs_stall", bus.o_stall, 0);
      chk("rs_efl", bus.o_enfreelist, 0);
      tick();
      chk("rs_valid", bus.o_valid, 0);
      probe("rs_map", 1, 2, 4, 0, 'h21, 'h20, 'h14, 0);

      for (int k = 0; k < NC; k++) begin
         drive('0, 4'b0000, '0, 4'b1111, 4'b0001);
         chk("fill_stall", bus.o_stall, 0);
         tick();
         chk("fill_id", bus.o_ckpt_id, 64'(k));
      end
      @(negedge clk);
      idle();
      #1;
      chk("full", bus.o_ckpt_full, 1);
      drive('0, 4'b0000, '0, 4'b1111, 4'b0001);
      chk("full_stall", bus.o_stall, 1);
      tick();
      chk("full_valid", bus.o_valid, 0);
      @(negedge clk);
      idle();
      bus.i_release = 1'b1;
      tick();
      drive('0, 4'b0000, '0, 4'b1111, 4'b0001);
      chk("rel_full", bus.o_ckpt_full, 0);
      chk("rel_stall", bus.o_stall, 0);
      tick();
      chk("wrap_id", bus.o_ckpt_id, 0);
      chk("wrap_valid", bus.o_valid, 1);

      drive({30'd0, ln(5,0,0), ln(0,0,0)}, 4'b0011,
            t4('h30,'h31,0,0), 4'b1111, 4'b0000);
      chk("r0_efl", bus.o_enfreelist, 4'b0001);
      tick();
      chk("r0_prd", bus.o_prd, t4(0,'h30,0,0));
      chk("r0_old", bus.o_oldprd, t4(0,5,0,0));

      drive({45'd0, ln(2,0,0)}, 4'b0001, t4('h40,0,0,0), 4'b1111, 4'b0000);
      #2;
      bus.i_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mr_valid", bus.o_valid, 0);
      chk("mr_prd", bus.o_prd, 0);
      chk("mr_old", bus.o_oldprd, 0);
      chk("mr_full", bus.o_ckpt_full, 0);
      @(negedge clk);
      rst_n = 1'b1;
      probe("mr_map", 1, 5, 2, 0, 1, 5, 2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rename_ckpt.md
RENAME_CKPT -- requirements
Module: rename_ckpt

Interface
REQ-001 Parameter WIDTH, default 4: rename lanes per group.
REQ-002 Parameter PRW, default 7: physical tag width.
REQ-003 Parameter ARW, default 5: architectural register index width.
REQ-004 Parameter NCKPT, default 4: branch checkpoints (power of two, >=2); CKW = log2(NCKPT).
REQ-005 i_clk  input  1  single clock, rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_en  input  1  rename group valid.
REQ-008 i_rg  input  WIDTH*3*ARW  per lane {rd, rs2, rs1}; rs1 in the LSBs; lane 0 in the LSBs.
REQ-009 i_wen  input  WIDTH  per-lane rd write enable.
REQ-010 i_freelist  input  WIDTH*PRW  free tags; slot 0 in the LSBs.
REQ-011 i_flvalid  input  WIDTH  thermometer count of valid freelist slots.
REQ-012 i_ckpt  input  WIDTH  lane is a branch and needs a snapshot after its rename; at most one bit set.
REQ-013 i_restore  input  1, i_restore_id  input  CKW: mispredict recovery.
REQ-014 i_release  input  1: free the oldest checkpoint (branch resolved correctly).
REQ-015 o_prs1, o_prs2, o_prd, o_oldprd  output  WIDTH*PRW each: registered rename results.
REQ-016 o_valid  output  1: registered; high when the group was accepted last cycle.
REQ-017 o_enfreelist  output  WIDTH: combinational thermometer count of freelist slots consumed this cycle.
REQ-018 o_stall  output  1: combinational; the group is not accepted.
REQ-019 o_ckpt_id  output  CKW: registered; snapshot id allocated for last accepted group.
REQ-020 o_ckpt_full  output  1: combinational; all checkpoints are in use.

Function
REQ-021 Map table: 2^ARW entries of PRW bits; arch register 0 always reads tag 0 and is never written.
REQ-022 A lane consumes a tag iff i_wen=1 and rd!=0; the k-th consuming lane, in lane order, takes i_freelist slot k.
REQ-023 Sources: rs of lane L takes the prd of the youngest lane <L in the group writing that rd, else the map table entry.
REQ-024 o_oldprd of lane L: the previous mapping of rd, with the same intra-group bypass; tag 0 when the lane does not consume a tag.
REQ-025 o_prd of lane L: the allocated tag, else 0.
REQ-026 o_stall = i_en & (consumers > popcount(i_flvalid), or any i_ckpt bit set while o_ckpt_full).
REQ-027 On stall or i_en=0: no map, freelist or checkpoint change; o_enfreelist=0; o_valid=0 next cycle; other outputs hold their value.
REQ-028 On acceptance: o_enfreelist = consumer count; the map table is updated with the final mapping of each rd (the youngest lane wins); outputs register on the same edge (1-cycle latency).
REQ-029 Checkpoint snapshot: the map state after all lanes <= the i_ckpt lane; stored at the tail, tail+1, count+1; o_ckpt_id = the old tail.
REQ-030 Checkpoints form a circular buffer (head, tail, count); wrap-around is modulo NCKPT; o_ckpt_full = (count == NCKPT).
REQ-031 i_release with count>0: head+1, count-1. With count=0 it is ignored.
REQ-032 i_restore: the map table loads snapshot i_restore_id; tail = i_restore_id; count = (i_restore_id - head) mod NCKPT.
REQ-033 i_restore is dominant: any rename group in the same cycle is dropped (o_stall=0, o_enfreelist=0, o_valid=0 next cycle).
REQ-034 i_release combined with i_restore: head advances first, then the count is computed. Releasing the restored id in that same cycle is illegal.

Reset
REQ-035 While i_rst_n=0, asynchronously: map entry i = i; head = tail = count = 0; all registered outputs = 0.
REQ-036 Reset mid-group discards that group; snapshot contents are don't-care after reset.

Verification (WIDTH=4, PRW=7)
REQ-037 Reset; rd=1..4, rs=0, wen=1111, freelist {14,13,12,11}h, flvalid=1111 -> prd 11h..14h, oldprd 1..4, prs 0, enfreelist=1111.
REQ-038 Next group: lane0 rd1/rs1=1; lane1 rd1/rs1=1; lane2 rd3/rs2=1; lane3 rd3/rs1=3; freelist {18,17,16,15}h.
 -> prs1 = 11h, 15h, -, 17h; lane2 prs2 = 16h; oldprd = 11h, 15h, 13h, 17h; map[1]=16h, map[3]=18h.
REQ-039 flvalid=0011 with 3 consumers -> o_stall=1, enfreelist=0, map unchanged, o_valid=0.
REQ-040 i_ckpt on lane1 then a further group remapping r1; i_restore to that id -> map[1] equals lane1's prd; count correct.
REQ-041 Fill 4 checkpoints -> o_ckpt_full=1; a branch group stalls; one i_release -> the next snapshot id wraps to 0.
REQ-042 rd=0 with wen=1 -> prd=0, no tag consumed. Assert i_rst_n low mid-stream -> outputs 0 and the identity map immediately.
